branch_predict_unit: RTL and testbench

Parametrised successor to the combinational next-PC/branch selector in the MIPS datapath. It predicts conditional branches in ID with a table of saturating counters and resolves them in EX. It emits a registered-stage redirect on misprediction, trains the table, and keeps branch/mispredict statistics. It also keeps the existing link write-back selection (rd/rt/r31, PC+8).

---
 rtl/branch_predict_unit_pkg.sv | 33 +++
 rtl/branch_predict_unit_bht_counter_table.sv | 60 ++++++
 rtl/branch_predict_unit.sv | 199 +++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared branch-type codes and counter helpers for the branch prediction unit.
// B_* codes match the datapath decoder encoding.
package branch_predict_unit_pkg;

    typedef enum logic [2:0] {
        B_BEQ  = 3'd0,
        B_BNE  = 3'd1,
        B_BLEZ = 3'd2,
        B_BGTZ = 3'd3,
        B_BLTZ = 3'd4,
        B_BGEZ = 3'd5,
        B_J    = 3'd6,
        B_JR   = 3'd7
    } branch_type_e;

    // Weakly-not-taken: one below the MSB-set threshold.
    function automatic int unsigned bp_ctr_reset(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned bp_weak_taken(input int unsigned ctr_bits);
        return 32'd1 << (ctr_bits - 32'd1);
    endfunction

    function automatic logic is_conditional(input logic [2:0] btype);
        return (btype != B_J) && (btype != B_JR);
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_predict_unit_bht_counter_table.sv
// Saturating-counter branch history table: async lookup, one synchronous
// training port, synchronous reset of every entry to weakly-not-taken.
module bht_counter_table
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned IDX_W    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                upd_en,
    input  logic [IDX_W-1:0]    upd_idx,
    input  logic                upd_taken
);

    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(bp_ctr_reset(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1'b1);

    logic [CTR_BITS-1:0] ctr_r [ENTRIES];
    logic [CTR_BITS-1:0] cur_s;
    logic [CTR_BITS-1:0] nxt_s;

    assign rd_ctr = ctr_r[rd_idx];

    // Saturating next value for the entry being trained.
    always_comb begin
        cur_s = ctr_r[upd_idx];
        nxt_s = cur_s;
        if (upd_taken) begin
            if (cur_s != CTR_MAX) begin
                nxt_s = cur_s + CTR_ONE;
            end else begin
                nxt_s = cur_s;
            end
        end else begin
            if (cur_s != CTR_ZERO) begin
                nxt_s = cur_s - CTR_ONE;
            end else begin
                nxt_s = cur_s;
            end
        end
    end

    // Counter storage: whole-table reset, single-entry training.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_r[i] <= CTR_INIT;
            end
        end else if (upd_en) begin
            ctr_r[upd_idx] <= nxt_s;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// ID-stage branch prediction with EX-stage resolution, redirect, table training,
// link write-back selection and branch statistics. One architectural delay slot.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned PREDICT_EN  = 1,
    parameter int unsigned STATS_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               id_valid,
    input  logic [31:0]        id_pc,
    input  logic [31:0]        id_instr,
    input  logic               id_branch,
    input  logic [2:0]         id_branch_type,
    input  logic               id_regdst,
    output logic               id_pred_taken,
    output logic [31:0]        id_pred_target,
    input  logic [31:0]        ex_reg_a,
    input  logic [31:0]        ex_reg_b,
    input  logic [31:0]        ex_alu_result,
    output logic [4:0]         ex_write_reg,
    output logic [31:0]        ex_result,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic [STATS_W-1:0] branch_count,
    output logic [STATS_W-1:0] mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0]    id_idx_s;
    logic [CTR_BITS-1:0] id_ctr_s;
    logic [31:0]         id_pc4_s;
    logic                id_taken_s;
    logic [31:0]         id_target_s;
    logic                unused_id_opcode_s;

    logic                ex_valid_r;
    logic [31:0]         ex_pc_r;
    logic [20:0]         ex_instr_r;
    logic                ex_branch_r;
    logic [2:0]          ex_type_r;
    logic                ex_regdst_r;
    logic                ex_pred_r;
    logic [IDX_W-1:0]    ex_idx_r;

    logic [31:0]         ex_pc8_s;
    logic                ex_actual_s;
    logic                ex_mispredict_s;
    logic [31:0]         ex_redirect_pc_s;
    logic                ex_resolve_s;
    logic                train_en_s;
    logic [STATS_W-1:0]  branch_count_r;
    logic [STATS_W-1:0]  mispredict_count_r;

    assign id_idx_s           = id_pc[IDX_W+1:2];
    assign id_pc4_s           = id_pc + 32'd4;
    assign unused_id_opcode_s = ^id_instr[31:26];

    bht_counter_table #(
        .ENTRIES (BHT_ENTRIES),
        .CTR_BITS(CTR_BITS),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (id_idx_s),
        .rd_ctr   (id_ctr_s),
        .upd_en   (train_en_s),
        .upd_idx  (ex_idx_r),
        .upd_taken(ex_actual_s)
    );

    // ID prediction: J always taken, JR left to EX, conditionals from counter MSB.
    always_comb begin
        id_taken_s  = 1'b0;
        id_target_s = id_pc + 32'd8;
        if (id_valid && id_branch) begin
            case (id_branch_type)
                B_J: begin
                    id_taken_s  = 1'b1;
                    id_target_s = {id_pc4_s[31:28], id_instr[25:0], 2'b00};
                end
                B_JR: begin
                    id_taken_s = 1'b0;
                end
                default: begin
                    if ((PREDICT_EN != 32'd0) && id_ctr_s[CTR_BITS-1]) begin
                        id_taken_s  = 1'b1;
                        id_target_s = branch_target(id_pc, id_instr[15:0]);
                    end else begin
                        id_taken_s = 1'b0;
                    end
                end
            endcase
        end else begin
            id_taken_s = 1'b0;
        end
    end

    assign id_pred_taken  = id_taken_s;
    assign id_pred_target = id_target_s;

    // ID/EX pipeline register; reset yields a bubble, stall holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_r  <= 1'b0;
            ex_pc_r     <= 32'd0;
            ex_instr_r  <= 21'd0;
            ex_branch_r <= 1'b0;
            ex_type_r   <= 3'd0;
            ex_regdst_r <= 1'b0;
            ex_pred_r   <= 1'b0;
            ex_idx_r    <= {IDX_W{1'b0}};
        end else if (!stall) begin
            ex_valid_r  <= id_valid;
            ex_pc_r     <= id_pc;
            ex_instr_r  <= id_instr[20:0];
            ex_branch_r <= id_branch;
            ex_type_r   <= id_branch_type;
            ex_regdst_r <= id_regdst;
            ex_pred_r   <= id_taken_s;
            ex_idx_r    <= id_idx_s;
        end
    end

    assign ex_pc8_s = ex_pc_r + 32'd8;

    // EX resolution: signed zero compares, equality compares, JR always redirects.
    always_comb begin
        ex_actual_s      = 1'b0;
        ex_mispredict_s  = 1'b0;
        ex_redirect_pc_s = ex_pc8_s;
        case (ex_type_r)
            B_BEQ:   ex_actual_s = (ex_reg_a == ex_reg_b);
            B_BNE:   ex_actual_s = (ex_reg_a != ex_reg_b);
            B_BLEZ:  ex_actual_s = ex_reg_a[31] || (ex_reg_a == 32'd0);
            B_BGTZ:  ex_actual_s = !ex_reg_a[31] && (ex_reg_a != 32'd0);
            B_BLTZ:  ex_actual_s = ex_reg_a[31];
            B_BGEZ:  ex_actual_s = !ex_reg_a[31];
            B_J:     ex_actual_s = ex_pred_r;
            B_JR:    ex_actual_s = 1'b1;
            default: ex_actual_s = 1'b0;
        endcase
        if (ex_type_r == B_JR) begin
            ex_mispredict_s  = 1'b1;
            ex_redirect_pc_s = ex_reg_a;
        end else if (ex_type_r == B_J) begin
            ex_mispredict_s = 1'b0;
        end else begin
            ex_mispredict_s  = (ex_actual_s != ex_pred_r);
            ex_redirect_pc_s = ex_actual_s ? branch_target(ex_pc_r, ex_instr_r[15:0]) : ex_pc8_s;
        end
    end

    assign ex_resolve_s   = ex_valid_r && ex_branch_r && !stall;
    assign train_en_s     = ex_resolve_s && is_conditional(ex_type_r);
    assign redirect_valid = ex_resolve_s && ex_mispredict_s;
    assign redirect_pc    = ex_redirect_pc_s;

    // Write-back select; a bubble presents zeros.
    always_comb begin
        ex_result    = 32'd0;
        ex_write_reg = 5'd0;
        if (!ex_valid_r) begin
            ex_result    = 32'd0;
            ex_write_reg = 5'd0;
        end else if (ex_branch_r) begin
            ex_result    = ex_pc8_s;
            ex_write_reg = (ex_type_r == B_JR) ? ex_instr_r[15:11] : 5'd31;
        end else begin
            ex_result    = ex_alu_result;
            ex_write_reg = ex_regdst_r ? ex_instr_r[15:11] : ex_instr_r[20:16];
        end
    end

    // Statistics counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count_r     <= {STATS_W{1'b0}};
            mispredict_count_r <= {STATS_W{1'b0}};
        end else begin
            if (ex_resolve_s) begin
                branch_count_r <= branch_count_r + STATS_W'(1'b1);
            end
            if (redirect_valid) begin
                mispredict_count_r <= mispredict_count_r + STATS_W'(1'b1);
            end
        end
    end

    assign branch_count     = branch_count_r;
    assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed vector table with hand-derived
// expectations, then randomized traffic against a behavioural model.
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;

    localparam int ENTRIES = 64;
    localparam logic [31:0] BEQ_I  = 32'h1022_0004;
    localparam logic [31:0] ALU3   = 32'h0000_1820;
    localparam logic [31:0] ALU7   = 32'h2007_0001;
    localparam logic [31:0] BLTZ_I = 32'h0420_FFFF;
    localparam logic [31:0] BGEZ_I = 32'h0421_0008;
    localparam logic [31:0] JR_I   = 32'h00A0_4808;
    localparam logic [31:0] J_I    = 32'h0800_0040;

    logic clk = 1'b0;
    logic rst_n, stall, id_valid, id_branch, id_regdst;
    logic [31:0] id_pc, id_instr, ex_reg_a, ex_reg_b, ex_alu_result;
    logic [2:0] id_branch_type;
    logic id_pred_taken, redirect_valid;
    logic [31:0] id_pred_target, ex_result, redirect_pc, branch_count, mispredict_count;
    logic [4:0] ex_write_reg;

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .id_branch(id_branch), .id_branch_type(id_branch_type),
        .id_regdst(id_regdst), .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .ex_reg_a(ex_reg_a), .ex_reg_b(ex_reg_b), .ex_alu_result(ex_alu_result),
        .ex_write_reg(ex_write_reg), .ex_result(ex_result), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rn; bit st; bit iv; logic [31:0] pc; logic [31:0] instr; bit br; logic [2:0] typ; bit rdst;
        logic [31:0] a; logic [31:0] b; logic [31:0] alu;
        bit ept; logic [31:0] etgt; bit erv; logic [31:0] erpc; logic [4:0] ewr; logic [31:0] eres;
        logic [31:0] ebc; logic [31:0] emc;
    } vec_t;

    typedef struct {
        bit valid; logic [31:0] pc; logic [31:0] instr; bit br; logic [2:0] typ; bit rdst; bit pred; int idx;
    } ex_t;

    int n_total = 0;
    int n_bad = 0;
    int ctr_m [ENTRIES];
    ex_t ex_m;
    logic [31:0] bc_m, mc_m;
    vec_t tv [$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(bit rn, bit st, bit iv, logic [31:0] pc, logic [31:0] instr, bit br,
                                logic [2:0] typ, bit rdst, logic [31:0] a, logic [31:0] b, logic [31:0] alu,
                                bit ept, logic [31:0] etgt, bit erv, logic [31:0] erpc, logic [4:0] ewr,
                                logic [31:0] eres, logic [31:0] ebc, logic [31:0] emc);
        vec_t v;
        v.rn = rn; v.st = st; v.iv = iv; v.pc = pc; v.instr = instr; v.br = br; v.typ = typ; v.rdst = rdst;
        v.a = a; v.b = b; v.alu = alu; v.ept = ept; v.etgt = etgt; v.erv = erv; v.erpc = erpc;
        v.ewr = ewr; v.eres = eres; v.ebc = ebc; v.emc = emc;
        return v;
    endfunction

    function automatic bit cond_type(input logic [2:0] t);
        return t <= B_BGEZ;
    endfunction

    function automatic logic [31:0] cond_dest(input logic [31:0] pc, input logic [31:0] instr);
        int off;
        off = $signed(instr[15:0]);
        return pc + 32'd4 + 32'(off * 4);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) ctr_m[i] = 1;
        ex_m = '{valid: 0, pc: 32'd0, instr: 32'd0, br: 0, typ: 3'd0, rdst: 0, pred: 0, idx: 0};
        bc_m = 32'd0;
        mc_m = 32'd0;
    endfunction

    task automatic step(input vec_t v, input bit use_exp, input int row);
        int idx;
        bit m_pt, m_act, m_mis, m_rv;
        logic [31:0] m_tgt, m_rpc, m_res;
        logic [4:0] m_wr;
        rst_n = v.rn; stall = v.st; id_valid = v.iv; id_pc = v.pc; id_instr = v.instr;
        id_branch = v.br; id_branch_type = v.typ; id_regdst = v.rdst;
        ex_reg_a = v.a; ex_reg_b = v.b; ex_alu_result = v.alu;
        #4;
        // ID prediction from the model's counters
        idx = int'((v.pc / 32'd4) % 32'(ENTRIES));
        m_pt = 0;
        m_tgt = v.pc + 32'd8;
        if (v.iv && v.br) begin
            if (v.typ == B_J) begin
                m_pt = 1;
                m_tgt = ((v.pc + 32'd4) & 32'hF000_0000) | (32'(v.instr[25:0]) * 32'd4);
            end else if (cond_type(v.typ) && ctr_m[idx] >= 2) begin
                m_pt = 1;
                m_tgt = cond_dest(v.pc, v.instr);
            end
        end
        // EX resolution of the instruction the model holds
        case (ex_m.typ)
            B_BEQ:   m_act = (v.a == v.b);
            B_BNE:   m_act = (v.a != v.b);
            B_BLEZ:  m_act = ($signed(v.a) <= 0);
            B_BGTZ:  m_act = ($signed(v.a) > 0);
            B_BLTZ:  m_act = ($signed(v.a) < 0);
            B_BGEZ:  m_act = ($signed(v.a) >= 0);
            B_J:     m_act = ex_m.pred;
            default: m_act = 1;
        endcase
        m_mis = (ex_m.typ == B_JR) ? 1'b1 : (ex_m.typ == B_J) ? 1'b0 : (m_act != ex_m.pred);
        m_rv = ex_m.valid && ex_m.br && m_mis && !v.st;
        m_rpc = (ex_m.typ == B_JR) ? v.a : (m_act ? cond_dest(ex_m.pc, ex_m.instr) : ex_m.pc + 32'd8);
        if (!ex_m.valid) begin
            m_res = 32'd0; m_wr = 5'd0;
        end else if (ex_m.br) begin
            m_res = ex_m.pc + 32'd8;
            m_wr = (ex_m.typ == B_JR) ? ex_m.instr[15:11] : 5'd31;
        end else begin
            m_res = v.alu;
            m_wr = ex_m.rdst ? ex_m.instr[15:11] : ex_m.instr[20:16];
        end
        chk("pred_taken", 32'(id_pred_taken), 32'(m_pt));
        chk("pred_target", id_pred_target, m_tgt);
        chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
        chk("write_reg", 32'(ex_write_reg), 32'(m_wr));
        chk("ex_result", ex_result, m_res);
        chk("branch_count", branch_count, bc_m);
        chk("mispredict_count", mispredict_count, mc_m);
        if (use_exp) begin
            chk($sformatf("row%0d_pred_taken", row), 32'(id_pred_taken), 32'(v.ept));
            chk($sformatf("row%0d_pred_target", row), id_pred_target, v.etgt);
            chk($sformatf("row%0d_redirect_valid", row), 32'(redirect_valid), 32'(v.erv));
            if (v.erv) chk($sformatf("row%0d_redirect_pc", row), redirect_pc, v.erpc);
            chk($sformatf("row%0d_write_reg", row), 32'(ex_write_reg), 32'(v.ewr));
            chk($sformatf("row%0d_ex_result", row), ex_result, v.eres);
            chk($sformatf("row%0d_branch_count", row), branch_count, v.ebc);
            chk($sformatf("row%0d_mispredict_count", row), mispredict_count, v.emc);
        end
        @(posedge clk);
        #1;
        if (!v.rn) begin
            model_reset();
        end else if (!v.st) begin
            if (ex_m.valid && ex_m.br) begin
                bc_m = bc_m + 32'd1;
                if (m_mis) mc_m = mc_m + 32'd1;
                if (cond_type(ex_m.typ)) begin
                    if (m_act && ctr_m[ex_m.idx] < 3) ctr_m[ex_m.idx]++;
                    if (!m_act && ctr_m[ex_m.idx] > 0) ctr_m[ex_m.idx]--;
                end
            end
            ex_m = '{valid: v.iv, pc: v.pc, instr: v.instr, br: v.br, typ: v.typ, rdst: v.rdst, pred: m_pt, idx: idx};
        end
    endtask

    function automatic logic [31:0] pick_reg();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t v;
        // rn st iv pc instr br typ rdst | a b alu | ept etgt erv erpc ewr eres bc mc
        tv.push_back(mk(1,0, 0,32'h0,32'h0,0,B_BEQ,0, 32'h0,32'h0,32'h1111, 0,32'h8, 0,32'h0, 5'd0,32'h0, 0,0));
        tv.push_back(mk(1,0, 1,32'h100,BEQ_I,1,B_BEQ,0, 32'h0,32'h0,32'h0, 0,32'h108, 0,32'h0, 5'd0,32'h0, 0,0));
        tv.push_back(mk(1,0, 1,32'h104,ALU3,0,B_BEQ,1, 32'h5,32'h5,32'hDEAD, 0,32'h10C, 1,32'h114, 5'd31,32'h108, 0,0));
        tv.push_back(mk(1,0, 1,32'h100,BEQ_I,1,B_BEQ,0, 32'h0,32'h0,32'h1234, 1,32'h114, 0,32'h0, 5'd3,32'h1234, 1,1));
        tv.push_back(mk(1,0, 1,32'h104,ALU7,0,B_BEQ,0, 32'h9,32'h9,32'h0, 0,32'h10C, 0,32'h0, 5'd31,32'h108, 1,1));
        tv.push_back(mk(1,0, 1,32'h100,BEQ_I,1,B_BEQ,0, 32'h0,32'h0,32'h55, 1,32'h114, 0,32'h0, 5'd7,32'h55, 2,1));
        tv.push_back(mk(1,0, 0,32'h0,32'h0,0,B_BEQ,0, 32'h3,32'h3,32'h0, 0,32'h8, 0,32'h0, 5'd31,32'h108, 2,1));
        tv.push_back(mk(1,0, 1,32'h100,BEQ_I,1,B_BEQ,0, 32'h0,32'h0,32'h0, 1,32'h114, 0,32'h0, 5'd0,32'h0, 3,1));
        tv.push_back(mk(1,0, 1,32'h304,BLTZ_I,1,B_BLTZ,0, 32'h1,32'h2,32'h0, 0,32'h30C, 1,32'h108, 5'd31,32'h108, 3,1));
        tv.push_back(mk(1,0, 1,32'h308,BGEZ_I,1,B_BGEZ,0, 32'hFFFF_FFFF,32'h0,32'h0, 0,32'h310, 1,32'h304, 5'd31,32'h30C, 4,2));
        tv.push_back(mk(1,0, 1,32'h400,JR_I,1,B_JR,0, 32'h8000_0000,32'h0,32'h0, 0,32'h408, 0,32'h0, 5'd31,32'h310, 5,3));
        tv.push_back(mk(1,0, 1,32'h1000_0000,J_I,1,B_J,0, 32'h2000,32'h0,32'h0, 1,32'h1000_0100, 1,32'h2000, 5'd9,32'h408, 6,3));
        tv.push_back(mk(1,0, 1,32'h100,BEQ_I,1,B_BEQ,0, 32'h0,32'h0,32'h0, 1,32'h114, 0,32'h0, 5'd31,32'h1000_0008, 7,4));
        // mispredicting BEQ held in EX by a three-cycle stall
        tv.push_back(mk(1,1, 0,32'h0,32'h0,0,B_BEQ,0, 32'h1,32'h2,32'h0, 0,32'h8, 0,32'h0, 5'd31,32'h108, 8,4));
        tv.push_back(mk(1,1, 1,32'h100,BEQ_I,1,B_BEQ,0, 32'h1,32'h2,32'h0, 1,32'h114, 0,32'h0, 5'd31,32'h108, 8,4));
        tv.push_back(mk(1,1, 1,32'h100,BEQ_I,1,B_BEQ,0, 32'h1,32'h2,32'h0, 1,32'h114, 0,32'h0, 5'd31,32'h108, 8,4));
        tv.push_back(mk(1,0, 0,32'h0,32'h0,0,B_BEQ,0, 32'h1,32'h2,32'h0, 0,32'h8, 1,32'h108, 5'd31,32'h108, 8,4));
        tv.push_back(mk(1,0, 1,32'h100,BEQ_I,1,B_BEQ,0, 32'h0,32'h0,32'h0, 0,32'h108, 0,32'h0, 5'd0,32'h0, 9,5));
        // aliasing 0x100/0x200 with same-cycle update and lookup, then reset mid-stream
        tv.push_back(mk(1,0, 1,32'h200,BEQ_I,1,B_BEQ,0, 32'h7,32'h7,32'h0, 0,32'h208, 1,32'h114, 5'd31,32'h108, 9,5));
        tv.push_back(mk(1,0, 1,32'h100,BEQ_I,1,B_BEQ,0, 32'h4,32'h4,32'h0, 1,32'h114, 1,32'h214, 5'd31,32'h208, 10,6));
        tv.push_back(mk(1,0, 0,32'h0,32'h0,0,B_BEQ,0, 32'h6,32'h6,32'h0, 0,32'h8, 0,32'h0, 5'd31,32'h108, 11,7));
        tv.push_back(mk(0,0, 1,32'h100,BEQ_I,1,B_BEQ,0, 32'h0,32'h0,32'h0, 1,32'h114, 0,32'h0, 5'd0,32'h0, 12,7));
        tv.push_back(mk(1,0, 1,32'h100,BEQ_I,1,B_BEQ,0, 32'h0,32'h0,32'h0, 0,32'h108, 0,32'h0, 5'd0,32'h0, 0,0));
        tv.push_back(mk(1,0, 1,32'h304,BLTZ_I,1,B_BLTZ,0, 32'h0,32'h0,32'h0, 0,32'h30C, 1,32'h114, 5'd31,32'h108, 0,0));

        rst_n = 1'b0; stall = 1'b0; id_valid = 1'b0; id_pc = 32'd0; id_instr = 32'd0;
        id_branch = 1'b0; id_branch_type = 3'd0; id_regdst = 1'b0;
        ex_reg_a = 32'd0; ex_reg_b = 32'd0; ex_alu_result = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        for (int r = 0; r < tv.size(); r++) step(tv[r], 1'b1, r);

        for (int n = 0; n < 3000; n++) begin
            v = mk(1,0, 0,32'h0,32'h0,0,B_BEQ,0, 32'h0,32'h0,32'h0, 0,32'h0, 0,32'h0, 5'd0,32'h0, 0,0);
            v.rn = ($urandom_range(0, 99) != 0);
            v.st = ($urandom_range(0, 99) < 15);
            v.iv = ($urandom_range(0, 99) < 85);
            v.pc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : ($urandom & 32'h0000_0FFC);
            v.instr = $urandom;
            v.br = ($urandom_range(0, 99) < 60);
            v.typ = 3'($urandom_range(0, 7));
            v.rdst = 1'($urandom_range(0, 1));
            v.a = pick_reg();
            v.b = ($urandom_range(0, 1) == 0) ? v.a : pick_reg();
            v.alu = $urandom;
            step(v, 1'b0, n);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
